// File: rtl/ip_axi_slave_write.sv
// AXI write-channel slave (AW/W/B).
// Accepts one write burst at a time, forwards every accepted W beat to a
// downstream data FIFO, publishes the burst base addresses and byte size to
// the memory side and returns a single B response per burst.
module ip_axi_slave_write #(
    parameter int unsigned UNIQUE_ID_SZ    = 3,
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned FIFO_ADDR_SHIFT = 7,
    parameter int unsigned FIFO_ADDR_WIDTH = 25,
    parameter int unsigned MEM_ADDR_SHIFT  = 7,
    parameter int unsigned MEM_ADDR_WIDTH  = 25
) (
    input  logic                       clock,
    input  logic                       reset_n,
    // AW channel
    output logic                       awready,
    input  logic                       awvalid,
    input  logic [ADDR_WIDTH-1:0]      awaddr,
    input  logic [7:0]                 awlen,
    input  logic [2:0]                 awsize,
    input  logic [UNIQUE_ID_SZ-1:0]    awid,
    // W channel
    output logic                       wready,
    input  logic                       wvalid,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [DATA_WIDTH/8-1:0]    wstrb,
    input  logic                       wlast,
    // B channel
    input  logic                       bready,
    output logic                       bvalid,
    output logic [1:0]                 bresp,
    output logic [UNIQUE_ID_SZ-1:0]    bid,
    // FIFO side
    output logic [DATA_WIDTH-1:0]      data_to_fifo,
    output logic [DATA_WIDTH/8-1:0]    strb_to_fifo,
    input  logic                       fifo_full,
    input  logic                       fifo_overflow,
    output logic                       fifo_push,
    // Memory side
    output logic [FIFO_ADDR_WIDTH-1:0] write_addr,
    output logic [MEM_ADDR_WIDTH-1:0]  write_addr_mem,
    output logic [12:0]                write_byte_sz,
    output logic                       write_req
);

    // Largest legal awsize for this data width (log2 of bytes per beat).
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESP
    } state_t;

    state_t                    state;
    logic [8:0]                beats_left;
    logic                      err;

    logic [ADDR_WIDTH-1:0]     fifo_shifted;
    logic [ADDR_WIDTH-1:0]     mem_shifted;
    logic                      unused_shift_bits;
    logic                      aw_hs;
    logic                      w_push;
    logic                      size_err;
    logic                      wlast_err;
    logic                      err_next;

    assign fifo_shifted      = awaddr >> FIFO_ADDR_SHIFT;
    assign mem_shifted       = awaddr >> MEM_ADDR_SHIFT;
    assign unused_shift_bits = ^{fifo_shifted, mem_shifted};

    assign aw_hs        = awvalid && awready;
    assign wready       = (state == DATA) && !fifo_full;
    assign w_push       = wvalid && wready;
    assign fifo_push    = w_push;
    assign data_to_fifo = wdata;
    assign strb_to_fifo = wstrb;

    assign size_err  = awsize > MAX_SIZE;
    // The burst ends on the beat count; wlast is only cross-checked against it.
    assign wlast_err = w_push && (wlast != (beats_left == 9'd1));
    // Includes this cycle's faults so the final beat's errors reach bresp.
    assign err_next  = err || wlast_err || ((state == DATA) && fifo_overflow);

    // Burst FSM with registered handshake, response and memory-side outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            awready        <= 1'b1;
            bvalid         <= 1'b0;
            bresp          <= '0;
            bid            <= '0;
            write_req      <= 1'b0;
            write_addr     <= '0;
            write_addr_mem <= '0;
            write_byte_sz  <= '0;
            beats_left     <= '0;
            err            <= 1'b0;
        end else begin
            write_req <= 1'b0;
            case (state)
                IDLE: begin
                    if (aw_hs) begin
                        bid            <= awid;
                        beats_left     <= {1'b0, awlen} + 9'd1;
                        write_addr     <= fifo_shifted[FIFO_ADDR_WIDTH-1:0];
                        write_addr_mem <= mem_shifted[MEM_ADDR_WIDTH-1:0];
                        write_byte_sz  <= ({5'b0, awlen} + 13'd1) << awsize;
                        err            <= size_err;
                        awready        <= 1'b0;
                        write_req      <= 1'b1;
                        state          <= DATA;
                    end
                end
                DATA: begin
                    err <= err_next;
                    if (w_push) begin
                        beats_left     <= beats_left - 9'd1;
                        write_addr_mem <= write_addr_mem + MEM_ADDR_WIDTH'(1);
                        if (beats_left == 9'd1) begin
                            bvalid <= 1'b1;
                            bresp  <= err_next ? 2'b10 : 2'b00;
                            state  <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ip_axi_slave_write.sv
// Testbench for ip_axi_slave_write: directed and randomized bursts checked
// against expectations computed from the burst parameters.
module tb_ip_axi_slave_write;

    logic        clock;
    logic        reset_n;
    logic        awready, awvalid;
    logic [63:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [2:0]  awid;
    logic        wready, wvalid;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        bready, bvalid;
    logic [1:0]  bresp;
    logic [2:0]  bid;
    logic [63:0] data_to_fifo;
    logic [7:0]  strb_to_fifo;
    logic        fifo_full, fifo_overflow, fifo_push;
    logic [24:0] write_addr;
    logic [24:0] write_addr_mem;
    logic [12:0] write_byte_sz;
    logic        write_req;

    int total = 0;
    int bad   = 0;

    logic [63:0] got_data[$];
    logic [7:0]  got_strb[$];
    logic [24:0] got_addr[$];

    ip_axi_slave_write #(
        .UNIQUE_ID_SZ   (3),
        .ADDR_WIDTH     (64),
        .DATA_WIDTH     (64),
        .FIFO_ADDR_SHIFT(7),
        .FIFO_ADDR_WIDTH(25),
        .MEM_ADDR_SHIFT (7),
        .MEM_ADDR_WIDTH (25)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .awready       (awready),
        .awvalid       (awvalid),
        .awaddr        (awaddr),
        .awlen         (awlen),
        .awsize        (awsize),
        .awid          (awid),
        .wready        (wready),
        .wvalid        (wvalid),
        .wdata         (wdata),
        .wstrb         (wstrb),
        .wlast         (wlast),
        .bready        (bready),
        .bvalid        (bvalid),
        .bresp         (bresp),
        .bid           (bid),
        .data_to_fifo  (data_to_fifo),
        .strb_to_fifo  (strb_to_fifo),
        .fifo_full     (fifo_full),
        .fifo_overflow (fifo_overflow),
        .fifo_push     (fifo_push),
        .write_addr    (write_addr),
        .write_addr_mem(write_addr_mem),
        .write_byte_sz (write_byte_sz),
        .write_req     (write_req)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every FIFO push mid-cycle, together with the memory address in use.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && fifo_push === 1'b1) begin
            got_data.push_back(data_to_fifo);
            got_strb.push_back(strb_to_fifo);
            got_addr.push_back(write_addr_mem);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_awready"}, awready, 1);
        chk({tag, "_bvalid"}, bvalid, 0);
        chk({tag, "_bresp"}, bresp, 0);
        chk({tag, "_bid"}, bid, 0);
        chk({tag, "_write_req"}, write_req, 0);
        chk({tag, "_write_addr"}, write_addr, 0);
        chk({tag, "_write_addr_mem"}, write_addr_mem, 0);
        chk({tag, "_write_byte_sz"}, write_byte_sz, 0);
        chk({tag, "_wready"}, wready, 0);
    endtask

    // One full burst. stall_pct<0 selects a directed 3-cycle fifo_full window;
    // flip_wlast>=0 inverts wlast on that beat; ovf_beat>=0 pulses fifo_overflow
    // on that beat; early_w cycles of W precede AW; abort_after>=0 resets after
    // that many accepted beats.
    task automatic run_burst(input string tag, input logic [63:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [2:0] id, input int stall_pct,
                             input int flip_wlast, input int ovf_beat, input int bdelay,
                             input int early_w, input int abort_after);
        int          n;
        logic [63:0] dat[$];
        logic [7:0]  stb[$];
        logic        wl[$];
        logic        exp_err;
        logic [24:0] base;
        int          i;
        int          cyc;
        logic        hs;
        logic        acc;
        logic        full;
        logic        ovf_done;

        n = int'(len) + 1;
        for (int k = 0; k < n; k++) begin
            dat.push_back({$urandom, $urandom});
            stb.push_back(8'($urandom));
            wl.push_back(k == n - 1);
        end
        if (flip_wlast >= 0 && flip_wlast < n) wl[flip_wlast] = !wl[flip_wlast];
        exp_err = (flip_wlast >= 0 && flip_wlast < n) || (ovf_beat >= 0 && ovf_beat < n) || (size > 3);
        base = 25'(addr >> 7);
        got_data.delete();
        got_strb.delete();
        got_addr.delete();

        wdata = dat[0];
        wstrb = stb[0];
        wlast = wl[0];
        for (int c = 0; c < early_w; c++) begin
            wvalid = 1'b1;
            @(negedge clock);
            chk({tag, "_early_nopush"}, fifo_push, 0);
            @(posedge clock);
            #1;
        end

        awvalid = 1'b1;
        awaddr  = addr;
        awlen   = len;
        awsize  = size;
        awid    = id;
        hs = 1'b0;
        for (int c = 0; c < 20 && !hs; c++) begin
            @(negedge clock);
            hs = awready;
            chk({tag, "_pre_aw_nopush"}, fifo_push, 0);
            @(posedge clock);
            #1;
        end
        awvalid = 1'b0;
        if (!hs) chk({tag, "_aw_timeout"}, 0, 1);
        chk({tag, "_write_req"}, write_req, 1);
        chk({tag, "_awready_busy"}, awready, 0);
        chk({tag, "_write_addr"}, write_addr, base);
        chk({tag, "_write_addr_mem0"}, write_addr_mem, base);
        chk({tag, "_byte_sz"}, write_byte_sz, 13'(((int'(len) + 1) << size) % 8192));

        i = 0;
        cyc = 0;
        ovf_done = 1'b0;
        while (i < n && cyc < n * 10 + 20) begin
            wvalid = 1'b1;
            wdata  = dat[i];
            wstrb  = stb[i];
            wlast  = wl[i];
            full = (stall_pct < 0) ? (cyc >= 2 && cyc < 5) : ($urandom_range(0, 99) < stall_pct);
            fifo_full = full;
            fifo_overflow = (i == ovf_beat) && !ovf_done;
            if (i == ovf_beat) ovf_done = 1'b1;
            @(negedge clock);
            acc = fifo_push;
            if (full) begin
                chk({tag, "_full_wready"}, wready, 0);
                chk({tag, "_full_nopush"}, fifo_push, 0);
            end
            @(posedge clock);
            #1;
            if (cyc == 0) chk({tag, "_write_req_pulse"}, write_req, 0);
            cyc++;
            if (acc) i++;
            if (abort_after >= 0 && i == abort_after) break;
        end
        wvalid = 1'b0;
        wlast = 1'b0;
        fifo_full = 1'b0;
        fifo_overflow = 1'b0;

        if (abort_after >= 0) begin
            #2 reset_n = 1'b0;
            #1;
            chk_reset_vals({tag, "_abort"});
            @(negedge clock);
            reset_n = 1'b1;
            for (int c = 0; c < 4; c++) begin
                @(posedge clock);
                #1;
                chk({tag, "_abort_nob"}, bvalid, 0);
                chk({tag, "_abort_awready"}, awready, 1);
            end
            return;
        end

        if (i < n) chk({tag, "_w_timeout"}, 0, 1);
        chk({tag, "_bvalid"}, bvalid, 1);
        chk({tag, "_bresp"}, bresp, exp_err ? 2'b10 : 2'b00);
        chk({tag, "_bid"}, bid, id);
        chk({tag, "_write_addr_held"}, write_addr, base);
        for (int d = 0; d < bdelay; d++) begin
            bready = 1'b0;
            @(posedge clock);
            #1;
            chk({tag, "_bvalid_hold"}, bvalid, 1);
            chk({tag, "_awready_hold"}, awready, 0);
        end
        bready = 1'b1;
        @(posedge clock);
        #1;
        bready = 1'b0;
        chk({tag, "_bvalid_done"}, bvalid, 0);
        chk({tag, "_awready_back"}, awready, 1);

        chk({tag, "_push_count"}, got_data.size(), n);
        for (int k = 0; k < n && k < got_data.size(); k++) begin
            chk({tag, "_data"}, got_data[k], dat[k]);
            chk({tag, "_strb"}, got_strb[k], stb[k]);
            chk({tag, "_mem_addr"}, got_addr[k], 25'(base + 25'(k)));
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        awvalid       = 1'b0;
        awaddr        = '0;
        awlen         = '0;
        awsize        = '0;
        awid          = '0;
        wvalid        = 1'b0;
        wdata         = '0;
        wstrb         = '0;
        wlast         = 1'b0;
        bready        = 1'b0;
        fifo_full     = 1'b0;
        fifo_overflow = 1'b0;
        #12;
        chk_reset_vals("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk_reset_vals("post_reset");

        // Basic 4-beat burst, back-to-back beats.
        run_burst("basic", 64'h1000, 8'd3, 3'd3, 3'd5, 0, -1, -1, 0, 0, -1);
        // FIFO full for 3 cycles mid-burst.
        run_burst("stall", 64'h2000, 8'd7, 3'd3, 3'd2, -1, -1, -1, 0, 0, -1);
        // Early wlast on a 2-beat burst.
        run_burst("wlast_early", 64'h3080, 8'd1, 3'd3, 3'd1, 0, 0, -1, 0, 0, -1);
        // Missing wlast on the final beat.
        run_burst("wlast_missing", 64'h3100, 8'd2, 3'd2, 3'd3, 0, 2, -1, 0, 0, -1);
        // FIFO overflow pulse during the burst.
        run_burst("overflow", 64'h4000, 8'd4, 3'd3, 3'd6, 0, -1, 2, 0, 0, -1);
        // Oversized beat size still pushes every beat but reports SLVERR.
        run_burst("size_err", 64'h5000, 8'd2, 3'd5, 3'd7, 0, -1, -1, 0, 0, -1);
        // W before AW, B held off for 5 cycles.
        run_burst("early_w", 64'h6000, 8'd2, 3'd3, 3'd4, 0, -1, -1, 5, 3, -1);
        // write_addr_mem wraps at the top of its range.
        run_burst("wrap", 64'h1_ffff_ff00, 8'd3, 3'd3, 3'd0, 0, -1, -1, 0, 0, -1);
        // Reset after beat 2 of an 8-beat burst, then a single-beat burst.
        run_burst("abort", 64'h7000, 8'd7, 3'd3, 3'd3, 0, -1, -1, 0, 0, 2);
        run_burst("after_abort", 64'h8000, 8'd0, 3'd3, 3'd2, 0, -1, -1, 0, 0, -1);

        // Randomized bursts.
        for (int r = 0; r < 10; r++) begin
            logic [7:0]  rl;
            logic [2:0]  rs;
            int          fw;
            int          ob;
            rl = 8'($urandom_range(0, 15));
            rs = 3'($urandom_range(0, 4));
            fw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(rl)) : -1;
            ob = ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(rl)) : -1;
            run_burst("rand", {$urandom, $urandom}, rl, rs, 3'($urandom), 30, fw, ob,
                      $urandom_range(0, 3), $urandom_range(0, 2), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
